// File: rtl/ds_adc_cic_mc.sv
// Multi-channel first-order delta-sigma ADC front end with sinc^ORDER decimation.
// Optional pdm_mon output port is enabled with `define DS_ADC_PDM_MON_EN.
module ds_adc_cic_mc #(
    parameter int CH    = 2,
    parameter int DIV   = 50,
    parameter int ORDER = 2,
    parameter int DEC   = 64,
    parameter int OUT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [CH-1:0]     dsm_in,
    output logic [CH-1:0]     dsm_out,
    output logic [CH*OUT_W-1:0] dout,
    output logic              dout_valid,
    output logic              cke_out
`ifdef DS_ADC_PDM_MON_EN
    ,
    output logic [CH*OUT_W-1:0] pdm_mon
`endif
);

    localparam int LD   = $clog2(DEC);
    localparam int DW   = $clog2(DIV);
    localparam int S    = ORDER * LD;
    localparam int RW   = S + 1;
    localparam int YW   = RW + 1;
    localparam int SH_L = (S >= OUT_W - 1) ? 0 : OUT_W - 1 - S;
    localparam int SH_R = (S >= OUT_W - 1) ? S - OUT_W + 1 : 0;
    localparam int EW   = YW + SH_L;
    localparam int HW   = EW - OUT_W + 1;
    localparam int STW  = (ORDER > 3) ? 3 : 2;

    logic [CH-1:0]  sync1;
    logic [CH-1:0]  sync2;
    logic [CH-1:0]  pdm;
    logic [DW-1:0]  div;
    logic [LD-1:0]  dcnt;
    logic [STW-1:0] settle;
    logic           int_en;
    logic           cke;
    logic           wrap;
    logic           settled;

    assign cke     = en && (div == DW'(DIV - 1));
    assign cke_out = cke;
    assign wrap    = int_en && (dcnt == LD'(DEC - 1));
    assign settled = (settle == STW'(ORDER));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= dsm_in;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div        <= '0;
            dcnt       <= '0;
            settle     <= '0;
            int_en     <= 1'b0;
            pdm        <= '0;
            dsm_out    <= '0;
            dout_valid <= 1'b0;
        end else if (!en) begin
            div        <= '0;
            dcnt       <= '0;
            settle     <= '0;
            int_en     <= 1'b0;
            pdm        <= '0;
            dsm_out    <= '0;
            dout_valid <= 1'b0;
        end else begin
            div        <= cke ? '0 : div + 1'b1;
            int_en     <= cke;
            dout_valid <= wrap && settled;
            if (cke) begin
                pdm     <= sync2;
                dsm_out <= sync2;
            end
            if (int_en)
                dcnt <= dcnt + 1'b1;
            if (wrap && !settled)
                settle <= settle + 1'b1;
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [ORDER-1:0][RW-1:0] acc;
        logic [ORDER-1:0][RW-1:0] acc_nx;
        logic [ORDER-1:0][RW-1:0] z;
        logic [ORDER:0][RW-1:0]   cy;
        logic signed [YW-1:0]     yext;
        logic signed [EW-1:0]     sc;
        logic [HW-1:0]            hi;
        logic [OUT_W-1:0]         q;
        logic [OUT_W-1:0]         q_r;

        always_comb begin
            acc_nx    = acc;
            acc_nx[0] = acc[0] + (pdm[c] ? RW'(1) : {RW{1'b1}});
            for (int k = 1; k < ORDER; k++)
                acc_nx[k] = acc[k] + acc[k-1];
            cy    = '0;
            cy[0] = acc_nx[ORDER-1];
            for (int k = 0; k < ORDER; k++)
                cy[k+1] = cy[k] - z[k];
            // +full scale aliases to -2^S in RW bits; the newest bit tells them apart
            if (pdm[c] && cy[ORDER] == {1'b1, {S{1'b0}}})
                yext = {2'b01, {S{1'b0}}};
            else
                yext = {cy[ORDER][RW-1], cy[ORDER]};
            sc = EW'(yext);
            sc = sc <<< SH_L;
            sc = sc >>> SH_R;
            hi = sc[EW-1:OUT_W-1];
            q  = sc[OUT_W-1:0];
            if (hi != '0 && hi != '1)
                q = sc[EW-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                             : {1'b0, {(OUT_W-1){1'b1}}};
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                acc <= '0;
                z   <= '0;
                q_r <= '0;
            end else if (!en) begin
                acc <= '0;
                z   <= '0;
            end else if (int_en) begin
                acc <= acc_nx;
                if (wrap) begin
                    z <= cy[ORDER-1:0];
                    if (settled)
                        q_r <= q;
                end
            end
        end

        assign dout[c*OUT_W +: OUT_W] = q_r;

`ifdef DS_ADC_PDM_MON_EN
        logic [OUT_W-1:0] mon_r;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst)
                mon_r <= '0;
            else if (int_en)
                mon_r <= pdm[c] ? {1'b0, {(OUT_W-1){1'b1}}}
                                : {1'b1, {(OUT_W-1){1'b0}}};
        end

        assign pdm_mon[c*OUT_W +: OUT_W] = mon_r;
`endif
    end

endmodule
